// File: rtl/mem_responder_pkg.sv
// Shared types and decode helpers for the data-memory responder and the
// mem/writeback stage that decodes the same size masks.
package mem_responder_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_e;

    localparam logic [3:0] MASK_B = 4'd1;
    localparam logic [3:0] MASK_H = 4'd3;
    localparam logic [3:0] MASK_W = 4'd15;

    typedef struct packed {
        logic [3:0] en;
        logic       misalign;
    } lane_t;

    // An unsupported size mask is reported as misaligned so callers need one fault flag.
    function automatic lane_t lane_enables(input logic [3:0] mask, input logic [1:0] off);
        lane_t      r;
        logic [7:0] sh;
        sh         = {4'b0000, mask} << off;
        r.en       = sh[3:0];
        r.misalign = (|sh[7:4]) || !(mask == MASK_B || mask == MASK_H || mask == MASK_W);
        return r;
    endfunction

    function automatic logic [31:0] byte_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/mem_responder_rdpipe.sv
// Fixed-latency delay line for read responses; a faulted entry emerges with zero data.
module mem_responder_rdpipe #(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_data,
    input  logic        i_err,
    output logic        o_valid,
    output logic [31:0] o_data
);

    logic [READ_LATENCY-1:0] r_vld;
    logic [READ_LATENCY-1:0] r_err;
    logic [31:0]             r_dat [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vld <= '0;
            r_err <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_dat[i] <= '0;
        end else begin
            r_vld[0] <= i_valid;
            r_err[0] <= i_err;
            r_dat[0] <= i_data;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    assign o_valid = r_vld[READ_LATENCY-1];
    assign o_data  = r_err[READ_LATENCY-1] ? 32'h0 : r_dat[READ_LATENCY-1];

endmodule

// File: rtl/mem_responder.sv
// Data-memory responder: byte-lane writes, fixed-latency reads, post-reset clear.
// Optional saturating request counters are built when MEM_RESPONDER_STATS_EN is defined.
//
// state | meaning
// CLEAR | zeroing one word per cycle; all requests dropped with an error pulse
// READY | servicing requests; left only by reset
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int          DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write_in,
    input  logic [31:0] mem_write_addr_in,
    input  logic [31:0] mem_write_data_in,
    input  logic [7:0]  mem_write_mask_in,
    input  logic        mem_read_in,
    input  logic [31:0] mem_read_addr_in,
    output logic [31:0] mem_read_data_out,
    output logic        mem_read_valid_out,
    output logic        mem_error_out,
`ifdef MEM_RESPONDER_STATS_EN
    output logic [31:0] stat_reads_out,
    output logic [31:0] stat_writes_out,
    output logic [31:0] stat_errors_out,
`endif
    output logic        ready_out
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [30:0] DEPTH_W = 31'(DEPTH);

    logic [31:0]   r_mem [DEPTH];
    state_e        r_state;
    state_e        w_state_nxt;
    logic [AW-1:0] r_clear_ptr;
    logic          r_ready;
    logic          r_error;

    logic [3:0]    w_mask;
    logic          w_active;
    logic [32:0]   w_wr_diff;
    logic [32:0]   w_rd_diff;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    lane_t         w_wr_lane;
    lane_t         w_rd_lane;
    logic          w_wr_fault;
    logic          w_rd_fault;
    logic          w_wr_ok;
    logic          w_rd_go;
    logic [31:0]   w_wr_data;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_rd_merged;
    logic [31:0]   w_rd_data;
    logic          w_err_nxt;
    logic          w_unused;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= CLEAR;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            CLEAR:   if (r_clear_ptr == AW'(DEPTH - 1)) w_state_nxt = READY;
            READY:   w_state_nxt = READY;
            default: w_state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset)                r_clear_ptr <= '0;
        else if (r_state == CLEAR) r_clear_ptr <= r_clear_ptr + AW'(1);
    end

    // 33-bit subtraction keeps addresses below BASE_ADDR from wrapping into range.
    assign w_mask     = mem_write_mask_in[3:0];
    assign w_active   = reset && (r_state == READY);
    assign w_wr_diff  = {1'b0, mem_write_addr_in} - {1'b0, BASE_ADDR};
    assign w_rd_diff  = {1'b0, mem_read_addr_in} - {1'b0, BASE_ADDR};
    assign w_wr_idx   = w_wr_diff[AW+1:2];
    assign w_rd_idx   = w_rd_diff[AW+1:2];
    assign w_wr_lane  = lane_enables(w_mask, mem_write_addr_in[1:0]);
    assign w_rd_lane  = lane_enables(w_mask, mem_read_addr_in[1:0]);
    assign w_wr_fault = (w_wr_diff[32:2] >= DEPTH_W) || w_wr_lane.misalign;
    assign w_rd_fault = (w_rd_diff[32:2] >= DEPTH_W) || w_rd_lane.misalign;
    assign w_wr_ok    = w_active && mem_write_in && !w_wr_fault;
    assign w_rd_go    = w_active && mem_read_in;
    assign w_wr_data  = mem_write_data_in << {mem_write_addr_in[1:0], 3'b000};
    assign w_rd_word  = r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clear_ptr] <= '0;
        end else if (w_wr_ok) begin
            for (int b = 0; b < 4; b++)
                if (w_wr_lane.en[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
        end
    end

    // Same-cycle write to the read word is forwarded lane by lane.
    always_comb begin
        w_rd_merged = w_rd_word;
        for (int b = 0; b < 4; b++)
            if (w_wr_ok && (w_wr_idx == w_rd_idx) && w_wr_lane.en[b])
                w_rd_merged[8*b +: 8] = w_wr_data[8*b +: 8];
    end

    assign w_rd_data = (w_rd_merged >> {mem_read_addr_in[1:0], 3'b000}) & byte_mask(w_mask);

    assign w_err_nxt = ((r_state == CLEAR) && (mem_write_in || mem_read_in))
                    || (w_rd_go && w_rd_fault)
                    || (w_active && mem_write_in && w_wr_fault);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_ready <= (r_state == READY);
            r_error <= w_err_nxt;
        end
    end

    mem_responder_rdpipe #(
        .READ_LATENCY(READ_LATENCY)
    ) u_rdpipe (
        .clk     (clk),
        .reset   (reset),
        .i_valid (w_rd_go),
        .i_data  (w_rd_data),
        .i_err   (w_rd_fault),
        .o_valid (mem_read_valid_out),
        .o_data  (mem_read_data_out)
    );

    assign ready_out     = r_ready;
    assign mem_error_out = r_error;

`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_errors;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_errors <= '0;
        end else begin
            if (w_rd_go && !w_rd_fault && (r_stat_reads != '1)) r_stat_reads <= r_stat_reads + 32'd1;
            if (w_wr_ok && (r_stat_writes != '1))               r_stat_writes <= r_stat_writes + 32'd1;
            if (w_err_nxt && (r_stat_errors != '1))             r_stat_errors <= r_stat_errors + 32'd1;
        end
    end

    assign stat_reads_out  = r_stat_reads;
    assign stat_writes_out = r_stat_writes;
    assign stat_errors_out = r_stat_errors;
`endif

    assign w_unused = ^{mem_write_mask_in[7:4], w_wr_diff[1:0], w_rd_diff[1:0], w_rd_lane.en};

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (read latency 1, 2, 3) share stimulus
// and are checked every cycle against a byte-addressed reference model.
module tb_mem_responder;

    localparam int      DEPTH = 16;
    localparam longint  BASE  = 0;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [7:0]  mask;
    logic        rd;
    logic [31:0] raddr;

    logic [31:0] rdata  [1:3];
    logic        rvalid [1:3];
    logic        err    [1:3];
    logic        rdy    [1:3];
`ifdef MEM_RESPONDER_STATS_EN
    logic [31:0] st_r [1:3];
    logic [31:0] st_w [1:3];
    logic [31:0] st_e [1:3];
`endif

    always #5 clk = ~clk;

    for (genvar g = 1; g <= 3; g++) begin : g_dut
        mem_responder #(
            .DEPTH(DEPTH), .BASE_ADDR(32'h0), .READ_LATENCY(g)
        ) u_dut (
            .clk                (clk),
            .reset              (reset),
            .mem_write_in       (wr),
            .mem_write_addr_in  (waddr),
            .mem_write_data_in  (wdata),
            .mem_write_mask_in  (mask),
            .mem_read_in        (rd),
            .mem_read_addr_in   (raddr),
            .mem_read_data_out  (rdata[g]),
            .mem_read_valid_out (rvalid[g]),
            .mem_error_out      (err[g]),
`ifdef MEM_RESPONDER_STATS_EN
            .stat_reads_out     (st_r[g]),
            .stat_writes_out    (st_w[g]),
            .stat_errors_out    (st_e[g]),
`endif
            .ready_out          (rdy[g])
        );
    end

    int          total = 0;
    int          bad   = 0;
    int unsigned m_edges;
    logic [7:0]  m_mem [DEPTH*4];
    logic        m_hv [0:4];
    logic [31:0] m_hd [0:4];
    logic        m_err;
    int unsigned m_sr, m_sw, m_se;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [3:0] m);
        case (m)
            4'd1:    return 1;
            4'd3:    return 2;
            4'd15:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit addr_bad(input logic [31:0] a, input int nb);
        longint la;
        la = longint'(a);
        return (nb == 0) || (la < BASE) || ((la - BASE) >= DEPTH * 4) || ((la % 4) + nb > 4);
    endfunction

    task automatic model_reset();
        m_edges = 0;
        for (int i = 0; i < DEPTH * 4; i++) m_mem[i] = 8'h00;
        for (int k = 0; k <= 4; k++) begin
            m_hv[k] = 1'b0;
            m_hd[k] = 32'h0;
        end
        m_err = 1'b0;
        m_sr = 0; m_sw = 0; m_se = 0;
    endtask

    // One clock: evaluate the request against the model, advance, then compare.
    task automatic cycle();
        logic        cv;
        logic [31:0] cd;
        logic        ce;
        int          nb;
        cv = 1'b0; cd = 32'h0; ce = 1'b0;
        if (reset) begin
            if (m_edges + 1 <= DEPTH) begin
                ce = wr | rd;
            end else begin
                nb = nbytes(mask[3:0]);
                if (wr) begin
                    if (addr_bad(waddr, nb)) ce = 1'b1;
                    else begin
                        for (int k = 0; k < nb; k++) m_mem[int'(waddr - 32'(BASE)) + k] = wdata[8*k +: 8];
                        m_sw++;
                    end
                end
                if (rd) begin
                    cv = 1'b1;
                    if (addr_bad(raddr, nb)) ce = 1'b1;
                    else begin
                        for (int k = 0; k < nb; k++)
                            cd = cd | (32'(m_mem[int'(raddr - 32'(BASE)) + k]) << (8 * k));
                        m_sr++;
                    end
                end
            end
            if (ce) m_se++;
        end
        @(posedge clk);
        if (!reset) model_reset();
        else begin
            if (m_edges < 100000) m_edges++;
            for (int k = 4; k >= 2; k--) begin
                m_hv[k] = m_hv[k-1];
                m_hd[k] = m_hd[k-1];
            end
            m_hv[1] = cv;
            m_hd[1] = cd;
            m_err   = ce;
        end
        #1;
        for (int g = 1; g <= 3; g++) begin
            chk("valid", rvalid[g], m_hv[g]);
            if (m_hv[g]) chk("rdata", rdata[g], m_hd[g]);
            chk("error", err[g], m_err);
            chk("ready", rdy[g], m_edges >= DEPTH + 1);
            if (!reset) chk("rst_data", rdata[g], 32'h0);
`ifdef MEM_RESPONDER_STATS_EN
            chk("stat_reads", st_r[g], m_sr);
            chk("stat_writes", st_w[g], m_sw);
            chk("stat_errors", st_e[g], m_se);
`endif
        end
    endtask

    task automatic req(input bit w, input logic [31:0] wa, input logic [31:0] wd,
                       input logic [7:0] m, input bit r, input logic [31:0] ra);
        wr = w; waddr = wa; wdata = wd; mask = m; rd = r; raddr = ra;
        cycle();
    endtask

    task automatic idle();
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFF0 | (t & 32'hF);
        return 32'($urandom_range(0, DEPTH * 4 + 7));
    endfunction

    function automatic logic [7:0] rand_mask();
        logic [31:0] t;
        int          s;
        t = $urandom;
        s = $urandom_range(0, 9);
        if (s < 3) return 8'h01;
        if (s < 6) return 8'h03;
        if (s < 9) return 8'h0F;
        return t[7:0];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        bit          seen;
        logic [31:0] a;
        reset = 1'b0;
        wr = 1'b0; waddr = 32'h0; wdata = 32'h0; mask = 8'h0F; rd = 1'b0; raddr = 32'h0;
        model_reset();
        repeat (3) idle();

        // Clear sequence; a request during it must be dropped with an error.
        reset = 1'b1;
        n = 0;
        while (!rdy[1] && n < 40) begin
            if (n == 2) req(1'b1, 32'h3C, 32'h55, 8'h0F, 1'b1, 32'h3C);
            else        idle();
            n++;
            if (n == 3) chk("clear_drop_err", err[1], 1'b1);
        end
        chk("ready_latency", n, DEPTH + 1);

        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h8);
        chk("idle_rd_valid", rvalid[1], 1'b1);
        chk("idle_rd_data", rdata[1], 32'h0);

        req(1'b1, 32'h10, 32'hDEADBEEF, 8'h0F, 1'b0, 32'h0);
        req(1'b1, 32'h11, 32'h000000AA, 8'h01, 1'b0, 32'h0);
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h10);
        chk("merge_rd", rdata[1], 32'hDEADAAEF);
        req(1'b0, 32'h0, 32'h0, 8'h03, 1'b1, 32'h12);
        chk("half_rd", rdata[1], 32'h0000DEAD);

        req(1'b1, 32'h13, 32'h0000BEEF, 8'h03, 1'b0, 32'h0);
        chk("misalign_err", err[1], 1'b1);
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h10);
        chk("misalign_unchanged", rdata[1], 32'hDEADAAEF);
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h40);
        chk("oor_valid", rvalid[1], 1'b1);
        chk("oor_data", rdata[1], 32'h0);
        chk("oor_err", err[1], 1'b1);

        req(1'b1, 32'h0, 32'd1, 8'h0F, 1'b0, 32'h0);
        req(1'b1, 32'h4, 32'd2, 8'h0F, 1'b0, 32'h0);
        req(1'b1, 32'h8, 32'd3, 8'h0F, 1'b0, 32'h0);
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h0);
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h4);
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h8);
        chk("lat3_v0", rvalid[3], 1'b1);
        chk("lat3_d0", rdata[3], 32'd1);
        idle();
        chk("lat3_d1", rdata[3], 32'd2);
        idle();
        chk("lat3_d2", rdata[3], 32'd3);
        idle();
        chk("lat3_end", rvalid[3], 1'b0);

        req(1'b1, 32'h20, 32'h12345678, 8'h0F, 1'b1, 32'h20);
        chk("fwd_rd", rdata[1], 32'h12345678);

        for (int i = 0; i < 500; i++) begin
            a = rand_addr();
            req(($urandom_range(0, 1) == 1), a, $urandom, rand_mask(),
                ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0) ? a : rand_addr());
        end
        repeat (4) idle();

        // Reset with reads in flight: nothing may emerge afterwards.
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h0);
        req(1'b0, 32'h0, 32'h0, 8'h0F, 1'b1, 32'h4);
        reset = 1'b0;
        idle();
`ifdef MEM_RESPONDER_STATS_EN
        chk("rst_stat_reads", st_r[2], 32'h0);
        chk("rst_stat_writes", st_w[2], 32'h0);
        chk("rst_stat_errors", st_e[2], 32'h0);
`endif
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < DEPTH + 4; i++) begin
            idle();
            if (rvalid[1] || rvalid[2] || rvalid[3]) seen = 1'b1;
            if (i < DEPTH) chk("rst_ready_low", rdy[2], 1'b0);
        end
        chk("no_valid_after_rst", seen, 1'b0);
        chk("ready_again", rdy[2], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
